// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high.
package seg_pkg;

  localparam int NUM_DIGITS = 5;

  // Segment patterns
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_P     = 8'h73;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Glyph codes fed to the glyph ROM; digits map to their own value
  localparam logic [3:0] GL_0     = 4'h0;
  localparam logic [3:0] GL_1     = 4'h1;
  localparam logic [3:0] GL_2     = 4'h2;
  localparam logic [3:0] GL_3     = 4'h3;
  localparam logic [3:0] GL_4     = 4'h4;
  localparam logic [3:0] GL_C     = 4'hA;
  localparam logic [3:0] GL_P     = 4'hB;
  localparam logic [3:0] GL_E     = 4'hC;
  localparam logic [3:0] GL_DASH  = 4'hD;
  localparam logic [3:0] GL_BLANK = 4'hF;

  // Digit positions; DIG_C is the leftmost digit
  typedef enum logic [2:0] {
    DIG_SPOT = 3'd0,
    DIG_P    = 3'd1,
    DIG_GAP  = 3'd2,
    DIG_CAP  = 3'd3,
    DIG_C    = 3'd4
  } digit_e;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph code to segment pattern map.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [7:0] pattern
);

  // Unknown codes render dark rather than showing garbage
  always_comb begin
    pattern = SEG_BLANK;
    case (glyph)
      GL_0:    pattern = SEG_0;
      GL_1:    pattern = SEG_1;
      GL_2:    pattern = SEG_2;
      GL_3:    pattern = SEG_3;
      GL_4:    pattern = SEG_4;
      GL_C:    pattern = SEG_C;
      GL_P:    pattern = SEG_P;
      GL_E:    pattern = SEG_E;
      GL_DASH: pattern = SEG_DASH;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Five-digit multiplexed seven-segment driver for the parking display.
// Shows "C<cap> P<spot>"; inputs are latched once per frame so a frame
// never tears, and each slot starts with a dark guard to avoid ghosting.
// Optional feature: define SEG_BLINK_FULL_EN to blink the display while
// the garage is full (capacity == 0).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            capacity,
  input  logic [1:0]            nearest_park,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] seg_select
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q;
  digit_e        idx_q;
  logic [2:0]    cap_q;
  logic [1:0]    park_q;
  logic          frame_start;
  logic          slot_last;
  logic          in_blank;
  logic          dark;
  logic [3:0]    glyph;
  logic [7:0]    pattern;

  assign frame_start = (idx_q == DIG_C) && (cnt_q == '0);
  assign slot_last   = (cnt_q == CNT_LAST);

  // Slot counter and digit index: leftmost digit first, wrapping per frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      idx_q <= DIG_C;
    end else if (slot_last) begin
      cnt_q <= '0;
      idx_q <= (idx_q == DIG_SPOT) ? DIG_C : digit_e'(idx_q - 3'd1);
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Frame latch: sample inputs only at the very start of a frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_q  <= 3'd0;
      park_q <= 2'd0;
    end else if (frame_start) begin
      cap_q  <= capacity;
      park_q <= nearest_park;
    end
  end

  // Anti-ghosting guard at the start of every slot
  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign in_blank = 1'b0;
    end else begin : g_guard
      assign in_blank = (cnt_q < CW'(BLANK_CYCLES));
    end
  endgenerate

  // Glyph selection for the current digit from the latched values
  always_comb begin
    glyph = GL_BLANK;
    case (idx_q)
      DIG_C:    glyph = GL_C;
      DIG_CAP:  glyph = (cap_q > 3'd4) ? GL_E : {1'b0, cap_q};
      DIG_GAP:  glyph = GL_BLANK;
      DIG_P:    glyph = GL_P;
      DIG_SPOT: glyph = (cap_q == 3'd0) ? GL_DASH : ({2'b00, park_q} + 4'd1);
      default:  glyph = GL_BLANK;
    endcase
  end

  seg_glyph_rom u_rom (
    .glyph   (glyph),
    .pattern (pattern)
  );

`ifdef SEG_BLINK_FULL_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_next;
  logic          blink_q;
  logic          blink_next;

  // fcnt counts frames already spent in the current blink phase; the new
  // phase takes effect on the frame-start edge itself, so a blinked frame
  // is dark from its first cycle.
  always_comb begin
    fcnt_next  = fcnt_q;
    blink_next = blink_q;
    if (frame_start) begin
      if (capacity != 3'd0) begin
        fcnt_next  = '0;
        blink_next = 1'b0;
      end else if (fcnt_q == FW'(BLINK_FRAMES)) begin
        fcnt_next  = FW'(1);
        blink_next = ~blink_q;
      end else begin
        fcnt_next  = fcnt_q + 1'b1;
      end
    end
  end

  // Blink phase state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_next;
      blink_q <= blink_next;
    end
  end

  assign dark = blink_next;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_FRAMES != 0);
  assign dark = 1'b0;
`endif

  // Registered outputs; dark during the guard window or a blinked frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seg_data   <= 8'h00;
      seg_select <= '0;
    end else if (in_blank || dark) begin
      seg_data   <= 8'h00;
      seg_select <= '0;
    end else begin
      seg_data   <= pattern;
      seg_select <= NUM_DIGITS'(1) << idx_q;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a frame-position reference
// model. Works with or without SEG_BLINK_FULL_EN defined.
module tb_seg_scan_driver;

  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 5 * RD;

  // Clock / reset
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] capacity = 3'd0;
  logic [1:0] nearest_park = 2'd0;
  logic [7:0] seg_data;
  logic [4:0] seg_select;

  initial forever #5 CLK = ~CLK;

  seg_scan_driver #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .capacity     (capacity),
    .nearest_park (nearest_park),
    .seg_data     (seg_data),
    .seg_select   (seg_select)
  );

  // Scoreboard counters and model state
  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // clock edges since reset release
  int m_cap    = 0;
  int m_park   = 0;
  int run      = 0;   // consecutive full-garage frames
  bit m_dark   = 1'b0;

  logic [7:0] dig_tab [0:4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed sel/data=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {seg_select, seg_data} for frame position p (0..FRAME-1)
  function automatic logic [12:0] model_out(int p, int cap, int park, bit dark);
    int         idx;
    logic [7:0] d;
    logic [4:0] sel;
    idx = 4 - p / RD;
    if (dark || (p % RD) < BC) return 13'h0;
    case (idx)
      4:       d = 8'h39;
      3:       d = (cap > 4) ? 8'h79 : dig_tab[cap];
      2:       d = 8'h00;
      1:       d = 8'h73;
      default: d = (cap == 0) ? 8'h40 : dig_tab[park + 1];
    endcase
    sel = 5'(1 << idx);
    return {sel, d};
  endfunction

  // Driver: advance one clock, update the model, compare
  task automatic tick(input string tag);
    int          p;
    logic [12:0] exp;
    p = k % FRAME;
    k++;
    if (p == 0) begin
      m_cap  = int'(capacity);
      m_park = int'(nearest_park);
`ifdef SEG_BLINK_FULL_EN
      if (m_cap == 0) begin
        run++;
        m_dark = (((run - 1) / BF) % 2) == 1;
      end else begin
        run    = 0;
        m_dark = 1'b0;
      end
`endif
    end
    exp = model_out(p, m_cap, m_park, m_dark);
    @(posedge CLK);
    #1;
    check(tag, {seg_select, seg_data}, exp);
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Advance until the next edge will be at frame position target
  task automatic run_to(input int target, input string tag);
    for (int i = 0; i < FRAME && (k % FRAME) != target; i++) tick(tag);
  endtask

  task automatic release_reset();
    RST    = 1'b1;
    k      = 0;
    run    = 0;
    m_dark = 1'b0;
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Directed and randomized sequence
  initial begin
    capacity     = 3'd3;
    nearest_park = 2'd2;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold", {seg_select, seg_data}, 13'h0);

    release_reset();
    tick("first_edge_dark");
    tick("first_lit");
    check("first_lit_direct", {seg_select, seg_data}, {5'b10000, 8'h39});
    run_cycles(FRAME * 2 - 2, "scan_c3_p2");

    // Capacity change during the gap slot must wait for the next frame
    run_to(2 * RD + 1, "to_gap");
    capacity = 3'd1;
    run_cycles(FRAME, "latch_hold");
    run_to(RD + 1, "to_cap");
    tick("cap1");
    check("cap1_direct", {seg_select, seg_data}, {5'b01000, 8'h06});

    // Full garage with varying nearest_park
    for (int f = 0; f < 4; f++) begin
      run_to(0, "full_align");
      capacity     = 3'd0;
      nearest_park = 2'($urandom_range(0, 3));
      run_cycles(FRAME, "full_garage");
    end

    // Out-of-range capacity
    run_to(0, "oor_align");
    capacity = 3'd6;
    run_cycles(FRAME, "cap_oor");

    // Random input changes at random frame positions
    for (int r = 0; r < 10; r++) begin
      run_to(int'($urandom_range(0, FRAME - 1)), "rand_to");
      capacity     = 3'($urandom_range(0, 7));
      nearest_park = 2'($urandom_range(0, 3));
      run_cycles(int'($urandom_range(1, FRAME)), "random");
    end

    // Reset asserted during the P slot: dark immediately
    capacity = 3'd4;
    run_to(0, "mid_align");
    run_to(3 * RD + 2, "to_p_slot");
    #2;
    RST = 1'b0;
    #1;
    check("reset_mid_immediate", {seg_select, seg_data}, 13'h0);
    @(posedge CLK);
    #1;
    check("reset_mid_hold", {seg_select, seg_data}, 13'h0);
    capacity     = 3'd2;
    nearest_park = 2'd1;
    release_reset();
    run_cycles(FRAME * 2, "after_reset");

    // Full garage for several frames, then recovery
    run_to(0, "blink_align");
    capacity = 3'd0;
    run_cycles(FRAME * 6, "blink_full");
    capacity = 3'd2;
    run_cycles(FRAME * 2, "blink_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
